data_mem_bus: RTL
=================

# data_mem_bus

Parametrised data-memory and peripheral bus block for the pipelined CPU's MEM stage. It holds an on-chip word RAM with byte/halfword/word access and sign/zero-extended loads, and routes all other mapped addresses to NUM_PERI peripheral windows. Peripheral accesses use a ready handshake with timeout. The block stalls the pipeline through `mem_wait` while a peripheral access is outstanding.

## Interface
Parameters:
- RAM_DEPTH, 256, number of 32-bit RAM words (power of 2, 16..4096)
- NUM_PERI, 4, number of peripheral windows (1..16)
- TIMEOUT, 15, maximum cycles spent waiting on `peri_ready` before error

Ports:
- clk  in  1  CPU clock; single clock domain
- reset  in  1  synchronous, active-high
- rd  in  1  load request (held by CPU while `mem_wait`)
- wr  in  1  store request (held by CPU while `mem_wait`)
- addr  in  32  byte address
- wdata  in  32  store data, right-aligned
- size  in  2  0 byte, 1 half, 2 word; 3 is treated as word
- load_signed  in  1  sign-extend byte/half loads
- rdata  out  32  load data, extended; 0 when not `rd`
- mem_wait  out  1  pipeline stall
- bus_err  out  1  one-cycle error pulse
- peri_sel  out  NUM_PERI  one-hot window select
- peri_rd, peri_wr  out  1 each  peripheral strobes
- peri_addr  out  8  byte offset within window
- peri_be  out  4  byte enables
- peri_wdata  out  32  lane-aligned write data
- peri_rdata  in  32*NUM_PERI  flattened; window k at [32k+:32]
- peri_ready  in  NUM_PERI  per-window completion

## Operation
- Address map:
  - RAM: `addr < RAM_DEPTH*4`.
  - Peripherals: `addr[31:12]==20'h40000`, window index `addr[11:8]`, which must be < NUM_PERI.
  - Anything else is unmapped.
- Lanes:
  - Byte uses `addr[1:0]`; half uses `addr[1]`.
  - Store data is replicated to the selected lane(s).
  - Load data is shifted down from the lane, then sign- or zero-extended.
- If `rd` and `wr` are asserted together, the access is a write and `rdata` is 0.
- RAM path: combinational read; write with byte enables at posedge. No stall.
- Unmapped access:
  - `bus_err` is high combinationally in the same cycle.
  - No write occurs; `rdata` is 0; no stall.
- Peripheral FSM states: IDLE, ACCESS, DONE, ERR.
  - IDLE → ACCESS on a mapped peripheral access. `mem_wait` is asserted combinationally in that same cycle. The request (sel, rd/wr, offset, be, wdata) is latched.
  - ACCESS: drive the latched request with strobes high every cycle and `mem_wait` high.
    - `peri_ready[sel]` → capture rdata into a register; go to DONE.
    - Counter reaches TIMEOUT → go to ERR.
  - DONE: strobes low, `mem_wait` low, `rdata` from the capture register. Go to IDLE.
  - ERR: `bus_err` high, `mem_wait` low, `rdata` = 0. Go to IDLE.
  - If `peri_ready` and the timeout coincide, ready wins.
- Timeout counter: width clog2(TIMEOUT+1); cleared on entering ACCESS; saturates.

## Timing
- Reset values:
  - FSM = IDLE; counter = 0; capture register = 0.
  - `mem_wait` = 0, `bus_err` = 0, `peri_sel` = 0, `peri_rd` = 0, `peri_wr` = 0.
  - `peri_addr` = 0, `peri_be` = 0, `peri_wdata` = 0, `rdata` = 0.
  - RAM contents are not reset.
- RAM load/store: 0 wait states.
- Peripheral access with ready after n cycles in ACCESS: stall of n+1 cycles (IDLE cycle + n ACCESS cycles). Result is visible in DONE.
- Ready in the first ACCESS cycle gives the minimum stall of 2 cycles.
- Timeout: stall of TIMEOUT+1 cycles, then one ERR cycle.
- Reset asserted mid-access: the FSM returns to IDLE at that edge. Strobes and `mem_wait` are low in the following cycle, and no write completes.
- The CPU must hold inputs stable while `mem_wait` is high. The block uses latched values regardless.

## Configuration
- DATA_MEM_MISALIGN_CHECK_EN
  - Defined: a half access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, is treated like an unmapped access: `bus_err` pulse, no write, `rdata` 0, no stall.
  - Undefined: low address bits are ignored for wider sizes (aligned down) and no error is raised.

## Structure
- Package `data_mem_pkg` holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - the FSM state enum;
  - PERI_BASE = 20'h40000;
  - the window-size constant 8.
- Sub-module `data_mem_lane`: combinational byte-enable generation, store replication and load extension. It is shared by the RAM and peripheral paths.

## Test plan
- Write word 0x12345678 at 0x10, then lb signed at 0x13 → 0x00000012; lh signed at 0x12 after sh 0x8001 → 0xFFFF8001; lhu → 0x00008001.
- sb 0xAB at 0x21 over word 0xFFFFFFFF → readback 0xFFFFABFF; no `mem_wait`.
- Read 0x40000104 with `peri_ready[1]` asserted on the 3rd ACCESS cycle and peri_rdata 0xCAFE0001 → `mem_wait` high for 4 cycles, `peri_sel`=0b0010, `peri_addr`=0x04, `rdata`=0xCAFE0001 in DONE.
- Write to window 2 with ready never asserted, TIMEOUT=15 → 16 stall cycles, then a one-cycle `bus_err`; `rdata` 0.
- Read 0x80000000 → same-cycle `bus_err`, `rdata` 0, no stall; with DATA_MEM_MISALIGN_CHECK_EN, sw to 0x02 → `bus_err` and RAM unchanged.
- Assert `reset` during the 2nd ACCESS cycle → next cycle IDLE, all strobes 0, `mem_wait` 0.

Source files
------------

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: size encodings, FSM states and address-map constants shared by
// the data memory / peripheral bus block and its bench.
package data_mem_pkg;
    localparam logic [1:0]  SZ_BYTE   = 2'd0;
    localparam logic [1:0]  SZ_HALF   = 2'd1;
    localparam logic [1:0]  SZ_WORD   = 2'd2;
    localparam logic [19:0] PERI_BASE = 20'h40000;
    localparam int          WIN_BITS  = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE,
        ST_ERR
    } state_t;
endpackage

// File: rtl/data_mem_lane.sv
// data_mem_lane: byte-enable generation, store-data lane replication and load
// extraction/extension; used for both the RAM and the peripheral path.
module data_mem_lane
    import data_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        load_signed,
    input  logic [31:0] wdata,
    input  logic [31:0] raw,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = raw[{offset, 3'b000} +: 8];
    assign half_v = raw[{offset[1], 4'b0000} +: 16];

    // Wider sizes ignore the low offset bits, so accesses are aligned down.
    always_comb begin
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = raw;
        case (size)
            SZ_BYTE: begin
                be         = 4'b0001 << offset;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {{24{load_signed & byte_v[7]}}, byte_v};
            end
            SZ_HALF: begin
                be         = offset[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {{16{load_signed & half_v[15]}}, half_v};
            end
            default: begin
                be         = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = raw;
            end
        endcase
    end
endmodule

// File: rtl/data_mem_bus.sv
// data_mem_bus: MEM-stage word RAM plus NUM_PERI peripheral windows with a
// ready/timeout handshake. Define DATA_MEM_MISALIGN_CHECK_EN to fault misaligned half/word accesses.
//   state     | meaning
//   ST_IDLE   | RAM / unmapped accesses served combinationally; peripheral request latched
//   ST_ACCESS | latched request driven with strobes, waiting for peri_ready or timeout
//   ST_DONE   | peripheral finished; captured load data presented, stall released
//   ST_ERR    | peripheral timed out; one-cycle bus_err, rdata 0
module data_mem_bus
    import data_mem_pkg::*;
#(
    parameter int RAM_DEPTH = 256,
    parameter int NUM_PERI  = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rd,
    input  logic                   wr,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    input  logic [1:0]             size,
    input  logic                   load_signed,
    output logic [31:0]            rdata,
    output logic                   mem_wait,
    output logic                   bus_err,
    output logic [NUM_PERI-1:0]    peri_sel,
    output logic                   peri_rd,
    output logic                   peri_wr,
    output logic [WIN_BITS-1:0]    peri_addr,
    output logic [3:0]             peri_be,
    output logic [31:0]            peri_wdata,
    input  logic [32*NUM_PERI-1:0] peri_rdata,
    input  logic [NUM_PERI-1:0]    peri_ready
);
    localparam int            AW        = $clog2(RAM_DEPTH);
    localparam int            CW        = $clog2(TIMEOUT + 1);
    localparam logic [31:0]   RAM_BYTES = 32'(RAM_DEPTH * 4);
    localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(TIMEOUT);

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt;
    logic [31:0]         cap;
    logic [NUM_PERI-1:0] lat_sel;
    logic                lat_rd, lat_wr, lat_signed;
    logic [1:0]          lat_size;
    logic [WIN_BITS-1:0] lat_addr;
    logic [3:0]          lat_be;
    logic [31:0]         lat_wdata;

    logic [31:0]         mem [RAM_DEPTH];
    logic [31:0]         ram_word, peri_word;
    logic [NUM_PERI-1:0] win_oh;
    logic                access, ram_hit, peri_hit, misalign, bad, start, ready_sel;
    logic [1:0]          ln_size, ln_off;
    logic                ln_signed;
    logic [31:0]         ln_raw, ln_wdata, ln_rdata;
    logic [3:0]          ln_be;

    assign access  = rd | wr;
    assign ram_hit = addr < RAM_BYTES;

    // An empty one-hot means the window index is beyond NUM_PERI.
    always_comb begin
        win_oh = '0;
        for (int k = 0; k < NUM_PERI; k++) win_oh[k] = (addr[11:8] == 4'(k));
    end
    assign peri_hit = (addr[31:12] == PERI_BASE) && (|win_oh);

`ifdef DATA_MEM_MISALIGN_CHECK_EN
    assign misalign = ((size == SZ_HALF) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign bad      = access && (!(ram_hit || peri_hit) || misalign);
    assign start    = (state == ST_IDLE) && access && peri_hit && !misalign;
    assign ram_word = mem[addr[AW+1:2]];

    always_comb begin
        peri_word = '0;
        for (int k = 0; k < NUM_PERI; k++)
            if (lat_sel[k]) peri_word = peri_rdata[32*k +: 32];
    end
    assign ready_sel = |(peri_ready & lat_sel);

    // Lane logic sees live CPU inputs in IDLE and the latched request otherwise.
    always_comb begin
        ln_size   = size;
        ln_off    = addr[1:0];
        ln_signed = load_signed;
        ln_raw    = ram_word;
        if (state != ST_IDLE) begin
            ln_size   = lat_size;
            ln_off    = lat_addr[1:0];
            ln_signed = lat_signed;
            ln_raw    = peri_word;
        end
    end

    data_mem_lane u_lane (
        .size        (ln_size),
        .offset      (ln_off),
        .load_signed (ln_signed),
        .wdata       (wdata),
        .raw         (ln_raw),
        .be          (ln_be),
        .wdata_lane  (ln_wdata),
        .rdata_ext   (ln_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset && (state == ST_IDLE) && wr && ram_hit && !misalign)
            for (int b = 0; b < 4; b++)
                if (ln_be[b]) mem[addr[AW+1:2]][8*b +: 8] <= ln_wdata[8*b +: 8];
    end

    always_comb begin
        state_nxt = state;
        rdata     = '0;
        mem_wait  = 1'b0;
        bus_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                bus_err = bad;
                if (start) begin
                    mem_wait  = 1'b1;
                    state_nxt = ST_ACCESS;
                end else if (rd && !wr && ram_hit && !misalign) begin
                    rdata = ln_rdata;
                end
            end
            ST_ACCESS: begin
                mem_wait = 1'b1;
                if (ready_sel)             state_nxt = ST_DONE;
                else if (cnt >= CNT_LAST)  state_nxt = ST_ERR;
            end
            ST_DONE: begin
                rdata     = lat_rd ? cap : '0;
                state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                bus_err   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        peri_sel   = '0;
        peri_rd    = 1'b0;
        peri_wr    = 1'b0;
        peri_addr  = '0;
        peri_be    = '0;
        peri_wdata = '0;
        if (state == ST_ACCESS) begin
            peri_sel   = lat_sel;
            peri_rd    = lat_rd;
            peri_wr    = lat_wr;
            peri_addr  = lat_addr;
            peri_be    = lat_be;
            peri_wdata = lat_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            cap        <= '0;
            lat_sel    <= '0;
            lat_rd     <= 1'b0;
            lat_wr     <= 1'b0;
            lat_signed <= 1'b0;
            lat_size   <= '0;
            lat_addr   <= '0;
            lat_be     <= '0;
            lat_wdata  <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                lat_sel    <= win_oh;
                lat_rd     <= rd & ~wr;
                lat_wr     <= wr;
                lat_signed <= load_signed;
                lat_size   <= size;
                lat_addr   <= addr[WIN_BITS-1:0];
                lat_be     <= ln_be;
                lat_wdata  <= ln_wdata;
                cnt        <= '0;
            end else if (state == ST_ACCESS) begin
                if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
                if (ready_sel)      cap <= ln_rdata;
            end
        end
    end
endmodule
